sym_packer_2to8: RTL and testbench

Downstream stage of the 2-bit 2:1 selector stage. Accepts the registered 2-bit symbol stream with a valid/ready handshake and packs four consecutive symbols, LSB-first, into one 8-bit word. Words leave through a 2-entry output buffer with valid/ready. A flush input closes a partially filled word with zero padding.

---
 rtl/sym_packer_pkg.sv | 30 +++
 rtl/sym_packer_2to8_sync_fifo2.sv | 54 +++++
 rtl/sym_packer_2to8.sv | 127 ++++++++++++
 tb/tb_sym_packer_2to8.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_packer_pkg.sv
// sym_packer_pkg: shared widths, types and state encoding for the 2-bit to
// 8-bit symbol packer. Optional build macro: SYM_PACKER_PARITY_EN adds a
// parity bit to every buffered word.
package sym_packer_pkg;

    localparam int SYM_W         = 2;
    localparam int SYMS_PER_WORD = 4;
    localparam int WORD_W        = SYM_W * SYMS_PER_WORD;
    localparam int FIFO_DEPTH    = 2;
    localparam int SYMS_W        = 3;

`ifdef SYM_PACKER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // One buffer entry: {parity (optional), symbol count, packed word}
    localparam int ENTRY_W = PAR_W + SYMS_W + WORD_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [2:0]        sym_cnt_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sym_packer_2to8_sync_fifo2.sv
// sync_fifo2: two-entry synchronous FIFO used as the packer's output buffer.
// A push is honoured when there is room or when a pop frees a slot in the
// same cycle; storage itself is not reset, only the pointers and count.
module sync_fifo2 #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Entry storage: written on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/sym_packer_2to8.sv
// sym_packer_2to8: packs four 2-bit symbols LSB-first into 8-bit words and
// hands them out through a 2-entry buffer. flush closes a partial word with
// zero padding. Optional build macro: SYM_PACKER_PARITY_EN adds out_parity.
module sym_packer_2to8
    import sym_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_syms,
    input  logic              out_ready
`ifdef SYM_PACKER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    state_t               state;
    state_t               state_n;
    sym_cnt_t             cnt;
    sym_cnt_t             cnt_n;
    sym_cnt_t             cnt_pk;
    word_t                acc;
    word_t                acc_n;
    word_t                acc_pk;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    word_t                push_word;
    sym_cnt_t             push_syms;
    logic [ENTRY_W-1:0]   din;
    logic [ENTRY_W-1:0]   dout;

    // in_ready depends only on registered state, never on out_ready or flush
    assign in_ready  = (state != FLUSH_WAIT) && ((cnt != 3'd3) || !full);
    assign accept    = in_valid && in_ready;
    assign pop       = !empty && out_ready;
    assign out_valid = !empty;

    // Fold an accepted symbol into the accumulator before any flush decision
    always_comb begin
        acc_pk = acc;
        cnt_pk = cnt;
        if (accept) begin
            acc_pk = acc | (word_t'(in_data) << {cnt[1:0], 1'b0});
            cnt_pk = cnt + 3'd1;
        end
    end

    // Decide whether a word leaves this cycle and where the FSM goes next
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_pk;
        acc_n     = acc_pk;
        push      = 1'b0;
        push_word = acc_pk;
        push_syms = cnt_pk;
        if (state == FLUSH_WAIT) begin
            if (!full) begin
                push    = 1'b1;
                cnt_n   = 3'd0;
                acc_n   = '0;
                state_n = IDLE;
            end
        end else if (cnt_pk == 3'd4) begin
            push    = 1'b1;
            cnt_n   = 3'd0;
            acc_n   = '0;
            state_n = IDLE;
        end else if (flush && (cnt_pk != 3'd0)) begin
            if (!full) begin
                push    = 1'b1;
                cnt_n   = 3'd0;
                acc_n   = '0;
                state_n = IDLE;
            end else begin
                state_n = FLUSH_WAIT;
            end
        end else begin
            state_n = (cnt_pk == 3'd0) ? IDLE : FILL;
        end
    end

    // Packer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            acc   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

`ifdef SYM_PACKER_PARITY_EN
    assign din        = {^push_word, push_syms, push_word};
    assign out_parity = empty ? 1'b0 : dout[ENTRY_W-1];
`else
    assign din        = {push_syms, push_word};
`endif

    assign out_data = empty ? '0 : dout[WORD_W-1:0];
    assign out_syms = empty ? 3'd0 : dout[WORD_W +: SYMS_W];

    sync_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sym_packer_2to8.sv
// tb_sym_packer_2to8: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model of the packer.
module tb_sym_packer_2to8;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_syms;
    logic       out_ready;
`ifdef SYM_PACKER_PARITY_EN
    logic       out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    sym_packer_2to8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_syms  (out_syms),
        .out_ready (out_ready)
`ifdef SYM_PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending symbols of the open word, queue of finished words
    logic [1:0] msyms[$];
    logic [7:0] mq_data[$];
    logic [2:0] mq_syms[$];
    bit         mwait;

    function automatic logic m_rdy();
        return !mwait && !(msyms.size() == 3 && mq_data.size() == 2);
    endfunction

    function automatic logic [7:0] m_pack();
        logic [7:0] w = 8'h00;
        foreach (msyms[k]) w = w | (8'(msyms[k]) << (2 * k));
        return w;
    endfunction

    function automatic void m_close();
        mq_data.push_back(m_pack());
        mq_syms.push_back(3'(msyms.size()));
        msyms.delete();
    endfunction

    function automatic void m_clear();
        msyms.delete();
        mq_data.delete();
        mq_syms.delete();
        mwait = 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs and compare DUT outputs against the model
    task automatic apply(input logic v, input logic [1:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        #1;
        chk("m_in_ready", 32'(in_ready), 32'(m_rdy()));
        chk("m_out_valid", 32'(out_valid), 32'(mq_data.size() > 0));
        if (mq_data.size() > 0) begin
            chk("m_out_data", 32'(out_data), 32'(mq_data[0]));
            chk("m_out_syms", 32'(out_syms), 32'(mq_syms[0]));
`ifdef SYM_PACKER_PARITY_EN
            chk("m_out_parity", 32'(out_parity), 32'(^mq_data[0]));
`endif
        end
    endtask

    // Clock edge plus model update from the same pre-edge inputs
    task automatic advance();
        logic rdy;
        logic full;
        logic acc;
        rdy  = m_rdy();
        full = (mq_data.size() == 2);
        acc  = in_valid && rdy;
        @(posedge clk);
        if (mq_data.size() > 0 && out_ready) begin
            void'(mq_data.pop_front());
            void'(mq_syms.pop_front());
        end
        if (mwait) begin
            if (!full) begin
                m_close();
                mwait = 1'b0;
            end
        end else begin
            if (acc) msyms.push_back(in_data);
            if (msyms.size() == 4) m_close();
            else if (flush && msyms.size() > 0) begin
                if (!full) m_close();
                else mwait = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 2'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_syms"}, 32'(out_syms), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef SYM_PACKER_PARITY_EN
        chk({tag, "_out_parity"}, 32'(out_parity), 32'd0);
`endif
    endtask

    typedef struct {
        logic       iv;
        logic [1:0] d;
        logic       fl;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_data;
        logic [2:0] exp_syms;
        logic       exp_par;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // iv, d, flush, out_ready | in_ready, out_valid, data, syms, parity
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h39, 3'd4, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 3'd2, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

        do_reset("rst0");

        // Directed table: full word, partial flush, flush in IDLE
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk($sformatf("t%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
                chk($sformatf("t%0d_out_syms", i), 32'(out_syms), 32'(tbl[i].exp_syms));
`ifdef SYM_PACKER_PARITY_EN
                chk($sformatf("t%0d_out_parity", i), 32'(out_parity), 32'(tbl[i].exp_par));
`endif
            end
            advance();
        end

        // Backpressure: 12 symbols with out_ready low, then drain in order
        do_reset("rst1");
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 2'((i + i / 4) % 4), 1'b0, 1'b0);
            if (i == 11) chk("bp_in_ready_full", 32'(in_ready), 32'd0);
            advance();
        end
        apply(1'b1, 2'd1, 1'b0, 1'b1);
        chk("bp_in_ready_pop", 32'(in_ready), 32'd0);
        chk("bp_word0", 32'(out_data), 32'hE4);
        advance();
        apply(1'b1, 2'd1, 1'b0, 1'b1);
        chk("bp_in_ready_room", 32'(in_ready), 32'd1);
        chk("bp_word1", 32'(out_data), 32'h39);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_word2", 32'(out_data), 32'h4E);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);
        advance();

        // Flush with buffer full at cnt=2 waits for room
        do_reset("rst2");
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 2'(i % 4), 1'b0, 1'b0);
            advance();
        end
        apply(1'b0, 2'd0, 1'b1, 1'b0);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b0);
        chk("fw_in_ready_wait", 32'(in_ready), 32'd0);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("fw_in_ready_pop", 32'(in_ready), 32'd0);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b0);
        chk("fw_in_ready_push", 32'(in_ready), 32'd0);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b0);
        chk("fw_in_ready_idle", 32'(in_ready), 32'd1);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("fw_word1", 32'(out_data), 32'hE4);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("fw_partial_data", 32'(out_data), 32'h04);
        chk("fw_partial_syms", 32'(out_syms), 32'd2);
        advance();

        // Fourth symbol together with flush gives exactly one full word
        do_reset("rst3");
        apply(1'b1, 2'd1, 1'b0, 1'b1); advance();
        apply(1'b1, 2'd2, 1'b0, 1'b1); advance();
        apply(1'b1, 2'd0, 1'b0, 1'b1); advance();
        apply(1'b1, 2'd3, 1'b1, 1'b1); advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ff_valid", 32'(out_valid), 32'd1);
        chk("ff_data", 32'(out_data), 32'hC9);
        chk("ff_syms", 32'(out_syms), 32'd4);
        advance();
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("ff_no_extra", 32'(out_valid), 32'd0);
        advance();

        // Reset mid-word with a buffered word discards everything
        do_reset("rst4");
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 2'(i % 4), 1'b0, 1'b0);
            advance();
        end
        do_reset("rst5");
        apply(1'b0, 2'd0, 1'b0, 1'b1);
        chk("rm_no_partial", 32'(out_valid), 32'd0);
        advance();

        // Randomized traffic against the model
        do_reset("rst6");
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
